cm0_trace_capture: RTL
======================

# cm0_trace_capture

Parametrised successor to the core's ad-hoc PC/register extraction taps: samples the processor's visible PC plus NUM_CH selected general-purpose registers, filters on a PC address window, timestamps qualifying samples and buffers them in a DEPTH-entry FIFO drained over a valid/ready stream. Sits beside the Cortex-M0 macro cell on HCLK, fed by its visibility outputs, and feeds the profiling/debug readout path.

## Interface
- NUM_CH, 3: number of 32-bit register channels captured alongside PC (1..4)
- DEPTH, 16: FIFO entries, power of two (4..256)
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- PC_I  in  32  processor PC (bit 0 always 0)
- REG_I  in  32*NUM_CH  register taps, channel k in bits [32k+31:32k]
- CFG_EN  in  1  capture enable (level)
- CFG_MODE  in  2  0=every PC change, 1=window entry only, 2=single-shot, 3=reserved (behaves as 0)
- CFG_LO / CFG_HI  in  32 each  inclusive PC window bounds
- TR_VALID  out  1  FIFO head valid
- TR_READY  in  1  consumer accepts head
- TR_DATA  out  32*(NUM_CH+1)+16  {TS[15:0], REG channels, PC}, PC in LSBs
- LEVEL  out  log2(DEPTH)+1  FIFO occupancy
- DROP_CNT  out  16  dropped samples, saturating
- STATE  out  2  0=IDLE 1=ARMED 2=RUN 3=STOPPED

## Operation
- Reset: all outputs 0, FIFO empty, state IDLE, timestamp 0, pc_prev 0, first flag set.
- in_win = (CFG_LO <= PC_I <= CFG_HI), unsigned; CFG_LO > CFG_HI means empty window (nothing captured).
- IDLE -> (CFG_EN rise) ARMED if MODE=2, else RUN. On that rise: timestamp, DROP_CNT cleared; first flag set; prev_in_win cleared. FIFO not flushed.
- ARMED -> RUN on first cycle with in_win; that cycle's sample is captured.
- RUN capture qualifier: MODE 0/2/3: in_win && (first || PC_I != pc_prev); MODE 1: in_win && !prev_in_win.
- first clears after first cycle in RUN; pc_prev and prev_in_win update every cycle in RUN/ARMED.
- RUN -> STOPPED (MODE 2 only) when a push makes FIFO full; no further captures, no drops counted.
- Any state -> IDLE when CFG_EN=0 (next cycle); FIFO contents retained and drainable. STOPPED exits only via CFG_EN low.
- CFG_MODE, CFG_LO, CFG_HI sampled live; changes mid-run take effect next cycle.
- Timestamp: 16-bit counter, increments every cycle while not IDLE, wraps 0xFFFF->0; entry carries value at capture cycle.
- FIFO push when qualifier && (!full || pop this cycle); qualifier && full && !pop -> sample discarded, DROP_CNT++ (holds at 0xFFFF).
- Pop when TR_VALID && TR_READY. Simultaneous push+pop at any level: LEVEL unchanged, both succeed.

## Timing
- Qualified sample at rising edge N appears at TR_DATA with TR_VALID=1 at N+1 if FIFO was empty (1-cycle latency, registered outputs).
- TR_DATA stable while TR_VALID && !TR_READY; head changes the cycle after a pop.
- LEVEL, DROP_CNT, STATE registered, updated the edge after the event.
- Pointers wrap modulo DEPTH; full = LEVEL==DEPTH, empty = LEVEL==0.
- HRESETn assertion mid-operation: immediate return to reset values regardless of HCLK; FIFO contents discarded.
- Max throughput: one push and one pop per cycle.

## Test plan
- Reset/idle: HRESETn low then high, CFG_EN=0, PC_I toggling -> TR_VALID=0, LEVEL=0, STATE=0, DROP_CNT=0.
- Mode 0: window 0x100-0x1FF, PC sequence 0x0F0,0x100,0x100,0x104,0x200,0x108, TR_READY=1 -> exactly 3 entries, PCs 0x100,0x104,0x108, timestamps 1,3,5 apart correctly relative to CFG_EN rise.
- Mode 1: same window, PC 0x100,0x104,0x300,0x110 -> 2 entries (0x100, 0x110).
- Overflow: DEPTH=16, TR_READY=0, 20 qualifying PCs -> LEVEL=16, DROP_CNT=4; then TR_READY=1 drains 16 entries in order, first PC equal to first captured.
- Single-shot: MODE=2, PCs outside window for 10 cycles (STATE=1, nothing pushed), then 20 in-window distinct PCs, TR_READY=0 -> STATE=3 after 16th push, LEVEL=16, DROP_CNT=0; CFG_EN low -> STATE=0.
- Edge cases: push+pop at LEVEL=16 keeps LEVEL=16 with no drop; timestamp wraps 0xFFFF->0x0000; async reset with LEVEL=7 -> LEVEL=0, TR_VALID=0 immediately.

Source files
------------

// File: rtl/cm0_trace_capture_if.sv
// Trace stream from the capture FIFO head to the profiling/debug readout path.
// A beat transfers on any rising HCLK where TR_VALID && TR_READY; while TR_VALID is high and
// TR_READY low the producer holds TR_DATA stable. TR_VALID never waits on TR_READY.
interface cm0_trace_capture_if #(
  parameter int DW = 144
);
  logic          TR_VALID;
  logic          TR_READY;
  logic [DW-1:0] TR_DATA;

  modport master (output TR_VALID, output TR_DATA, input TR_READY);
  modport slave  (input TR_VALID, input TR_DATA, output TR_READY);
endinterface

// File: rtl/cm0_trace_capture.sv
// PC/register trace capture: window filter, timestamping, DEPTH-entry FIFO drained
// over a valid/ready stream. Runs on HCLK beside the Cortex-M0 visibility taps.
module cm0_trace_capture #(
  parameter  int NUM_CH = 3,
  parameter  int DEPTH  = 16,
  localparam int DW     = 32 * (NUM_CH + 1) + 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = AW + 1
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [31:0]            PC_I,
  input  logic [32*NUM_CH-1:0]   REG_I,
  input  logic                   CFG_EN,
  input  logic [1:0]             CFG_MODE,
  input  logic [31:0]            CFG_LO,
  input  logic [31:0]            CFG_HI,
  cm0_trace_capture_if.master    tr,
  output logic [LW-1:0]          LEVEL,
  output logic [15:0]            DROP_CNT,
  output logic [1:0]             STATE
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RUN     = 2'd2,
    ST_STOPPED = 2'd3
  } state_e;

  state_e          state_q;
  logic [15:0]     ts_q;
  logic [15:0]     drop_q;
  logic [31:0]     pc_prev_q;
  logic            prev_in_win_q;
  logic            first_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic [DW-1:0]   mem_q [DEPTH];

  logic            in_win;
  logic            sampling;
  logic            qual;
  logic            capture;
  logic            full;
  logic            empty;
  logic            pop;
  logic            push;
  logic            drop;
  logic            stop_hit;
  logic [LW-1:0]   level_d;
  logic [15:0]     drop_d;
  logic [DW-1:0]   entry;

  always_comb begin
    in_win   = (PC_I >= CFG_LO) && (PC_I <= CFG_HI);
    // ARMED's first in-window cycle is treated as the first RUN sample.
    sampling = (state_q == ST_RUN) || ((state_q == ST_ARMED) && in_win);
    if (CFG_MODE == 2'd1) qual = in_win && !prev_in_win_q;
    else                  qual = in_win && (first_q || (PC_I != pc_prev_q));
    capture  = sampling && qual;
    full     = (level_q == LW'(DEPTH));
    empty    = (level_q == '0);
    pop      = !empty && tr.TR_READY;
    push     = capture && (!full || pop);
    drop     = capture && full && !pop;
    stop_hit = (CFG_MODE == 2'd2) && push && !pop && (level_q == LW'(DEPTH - 1));
    entry    = {ts_q, REG_I, PC_I};

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    drop_d = drop_q;
    if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q       <= ST_IDLE;
      ts_q          <= '0;
      drop_q        <= '0;
      pc_prev_q     <= '0;
      prev_in_win_q <= 1'b0;
      first_q       <= 1'b1;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;

      case (state_q)
        ST_IDLE: begin
          // FIFO is deliberately left alone so an earlier capture can still drain.
          if (CFG_EN) begin
            state_q       <= (CFG_MODE == 2'd2) ? ST_ARMED : ST_RUN;
            ts_q          <= '0;
            drop_q        <= '0;
            first_q       <= 1'b1;
            prev_in_win_q <= 1'b0;
          end
        end
        default: begin
          ts_q   <= ts_q + 16'd1;
          drop_q <= drop_d;
          if (state_q != ST_STOPPED) begin
            pc_prev_q     <= PC_I;
            prev_in_win_q <= in_win;
          end
          if (sampling) first_q <= 1'b0;

          if (!CFG_EN)                                state_q <= ST_IDLE;
          else if ((state_q == ST_ARMED) && in_win)   state_q <= ST_RUN;
          else if ((state_q == ST_RUN) && stop_hit)   state_q <= ST_STOPPED;
        end
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) mem_q[wr_ptr_q] <= entry;
  end

  assign tr.TR_VALID = !empty;
  assign tr.TR_DATA  = empty ? '0 : mem_q[rd_ptr_q];
  assign LEVEL       = level_q;
  assign DROP_CNT    = drop_q;
  assign STATE       = state_q;

endmodule
